debug_if_player: RTL
====================

// Module: debug_if_player
// PURPOSE
//  Active counterpart of the passive debug_if capture: drives an if_axi_stream
//  master port from a small on-chip beat buffer loaded via a simple write port.
//  Used in bring-up to inject known packets into a block under debug without host
//  traffic. Honours rdy backpressure; optional continuous loop replay.
// PARAMETERS
//  DAT_BYTS  8                 data bytes per beat
//  DAT_BITS  DAT_BYTS*8        data width
//  MOD_BITS  DAT_BYTS==1 ? 1 : $clog2(DAT_BYTS)   mod width
//  CTL_BITS  8                 ctl width
//  DEPTH     64                beat buffer entries, power of 2, >=2
// PORTS
//  i_clk      in   1         clock
//  i_rst      in   1         async reset, active-high
//  i_wr_val   in   1         load one beat (IDLE only)
//  i_wr_beat  in   ENTRY_W   {err,sop,eop,mod,ctl,dat} beat to load
//  o_wr_full  out  1         buffer holds DEPTH beats
//  i_clear    in   1         empty buffer (IDLE only)
//  i_start    in   1         begin replay from entry 0
//  i_loop     in   1         sampled at i_start: wrap to entry 0 after last beat
//  i_stop     in   1         end replay at next eop handshake
//  i_gap      in   8         idle cycles between packets (see CONFIGURATION)
//  o_busy     out  1         state != IDLE
//  o_done     out  1         1-cycle pulse on return to IDLE
//  o_if       if   -         if_axi_stream master (val/sop/eop/err/ctl/dat/mod out, rdy in)
// BEHAVIOUR
//  Reset: o_if.val/sop/eop/err=0, ctl/dat/mod=0, o_busy=0, o_done=0,
//   o_wr_full=0, count=0, rd_ptr=0, state=IDLE. Async assert clears o_if.val in
//   the same cycle even mid-packet; no partial-packet recovery.
//  Load: in IDLE, i_wr_val && !full writes entry[count], count++. Ignored when
//   full or not IDLE. i_clear in IDLE sets count=0; i_clear wins over i_wr_val.
//  FSM: IDLE -> FETCH on i_start && count!=0; i_start with count==0 stays IDLE,
//   o_done pulses next cycle. FETCH (1 cycle, RAM read latency) -> PLAY.
//   PLAY: output register loaded from RAM; first o_if.val 2 cycles after i_start.
//   PLAY -> GAP after eop handshake when gap feature on and i_gap!=0; GAP counts
//   i_gap cycles, val=0, then -> PLAY. PLAY -> IDLE after handshake of entry
//   count-1 with loop=0, or after any eop handshake once stop latched.
//  Handshake: beat transfers when val && rdy. Once val=1, all fields held stable
//   until transfer. Next beat presented in the cycle after transfer (prefetch),
//   so with rdy=1 constantly the stream is back-to-back, 1 beat/cycle.
//  Wrap: loop=1 -> rd_ptr wraps count-1 -> 0 with no bubble. rd_ptr width
//   $clog2(DEPTH); count width $clog2(DEPTH)+1.
//  i_stop: latched sticky while busy; cleared on entry to IDLE. In IDLE ignored.
//   If buffer holds no eop and loop=1, stop takes effect at end of entry count-1.
//  Simultaneous i_start and i_wr_val in IDLE: write accepted, start uses new count.
//  Buffer contents preserved across replays; i_start while busy ignored.
// CONFIGURATION
//  DEBUG_IF_PLAYER_GAP_EN defined: GAP state present, i_gap inserts idle cycles
//   after each eop handshake (not after final beat). Undefined: no GAP state,
//   i_gap ignored, packets back-to-back.
// STRUCTURE
//  debug_if_pkg: typedef player_state_t {IDLE,FETCH,PLAY,GAP}; ENTRY_W function
//   of DAT_BITS/CTL_BITS/MOD_BITS; beat struct pack/unpack helpers.
//  Sub-module debug_if_player_ram: simple dual-port RAM, 1 write/1 registered
//   read port, DEPTH x ENTRY_W.
// TESTING
//  Load 4 beats (sop on 0, eop on 3, dat=0x11..0x44), start, rdy=1 -> val at
//   cycle+2, 4 consecutive beats in order, o_done pulse, val=0 after.
//  Same load, rdy toggled 1010..: each beat held stable while rdy=0; 4 transfers.
//  loop=1, 2 packets of 3 beats, i_stop asserted mid-packet 2 of 2nd pass ->
//   replay ends exactly at that packet's eop; o_busy falls next cycle.
//  Write 65 beats with DEPTH=64 -> o_wr_full after 64th, 65th dropped, replay
//   yields 64 beats; i_start with count=0 -> no val, o_done pulse.
//  GAP_EN, i_gap=3, two 2-beat packets -> exactly 3 val=0 cycles between eop
//   and next sop; without macro -> 0 cycles.
//  Assert i_rst mid-packet -> val=0 immediately; after release, i_start with
//   reloaded buffer replays from entry 0.

Source files
------------

// File: rtl/debug_if_pkg.sv
// Shared types and helpers for the debug_if player.
// State encoding, beat entry width, and a packed beat struct for the
// default configuration (8 data bytes, 8 ctl bits).
package debug_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } player_state_t;

    // Width of the mod field for a given number of data bytes.
    function automatic int mod_bits(input int dat_byts);
        return (dat_byts == 1) ? 1 : $clog2(dat_byts);
    endfunction

    // One buffer entry is {err,sop,eop,mod,ctl,dat}.
    function automatic int entry_w(input int dat_bits, input int ctl_bits, input int mod_w);
        return 3 + mod_w + ctl_bits + dat_bits;
    endfunction

    localparam int DEF_DAT_BYTS = 8;
    localparam int DEF_DAT_BITS = DEF_DAT_BYTS * 8;
    localparam int DEF_MOD_BITS = mod_bits(DEF_DAT_BYTS);
    localparam int DEF_CTL_BITS = 8;
    localparam int DEF_ENTRY_W  = entry_w(DEF_DAT_BITS, DEF_CTL_BITS, DEF_MOD_BITS);

    // Field order matches the buffer entry layout, err in the MSB.
    typedef struct packed {
        logic                    err;
        logic                    sop;
        logic                    eop;
        logic [DEF_MOD_BITS-1:0] mod;
        logic [DEF_CTL_BITS-1:0] ctl;
        logic [DEF_DAT_BITS-1:0] dat;
    } beat_t;

    function automatic logic [DEF_ENTRY_W-1:0] pack_beat(input beat_t b);
        return b;
    endfunction

    function automatic beat_t unpack_beat(input logic [DEF_ENTRY_W-1:0] e);
        return beat_t'(e);
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Streaming interface: val/rdy handshake with sop/eop framing, err, ctl,
// data and mod (valid byte count of the last beat).
interface if_axi_stream #(
    parameter int DAT_BYTS = 8,
    parameter int CTL_BITS = 8
);
    localparam int DAT_BITS = DAT_BYTS * 8;
    localparam int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS);

    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [CTL_BITS-1:0] ctl;
    logic [DAT_BITS-1:0] dat;
    logic [MOD_BITS-1:0] mod;

    modport mst (output val, sop, eop, err, ctl, dat, mod, input rdy);
    modport slv (input val, sop, eop, err, ctl, dat, mod, output rdy);
endinterface

// File: rtl/debug_if_player_ram.sv
// Beat buffer: simple dual-port RAM, one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data,
// so a start issued together with the very first load sees that beat.
module debug_if_player_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    // Registered read port with write-through on address collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rd <= (we && (wa == ra)) ? wd : mem[ra];
        end
    end
endmodule

// File: rtl/debug_if_player.sv
// debug_if_player: replays beats from an on-chip buffer onto a stream master.
// Beats are loaded while idle; replay starts at entry 0, honours rdy
// backpressure, optionally loops, and stops at the next eop once requested.
// Build option: define DEBUG_IF_PLAYER_GAP_EN to insert i_gap idle cycles
// after each non-final eop handshake.
module debug_if_player
    import debug_if_pkg::*;
#(
    parameter int DAT_BYTS  = 8,
    parameter int DAT_BITS  = DAT_BYTS * 8,
    parameter int MOD_BITS  = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS),
    parameter int CTL_BITS  = 8,
    parameter int DEPTH     = 64,
    localparam int ENTRY_W  = entry_w(DAT_BITS, CTL_BITS, MOD_BITS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_val,
    input  logic [ENTRY_W-1:0] i_wr_beat,
    output logic               o_wr_full,
    input  logic               i_clear,
    input  logic               i_start,
    input  logic               i_loop,
    input  logic               i_stop,
    input  logic [7:0]         i_gap,
    output logic               o_busy,
    output logic               o_done,
    if_axi_stream.mst          o_if
);
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int CTL_LO = DAT_BITS;
    localparam int MOD_LO = CTL_LO + CTL_BITS;
    localparam int EOP_B  = MOD_LO + MOD_BITS;
    localparam int SOP_B  = EOP_B + 1;
    localparam int ERR_B  = EOP_B + 2;

    player_state_t       state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;     // index of the beat held in the RAM read register
    logic [AW-1:0]       out_idx_q, out_idx_d;   // index of the beat in the output register
    logic                loop_q, loop_d;
    logic                stop_q, stop_d;
    logic                done_q, done_d;
    logic                val_q, val_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                err_q, err_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic [DAT_BITS-1:0] dat_q, dat_d;
    logic [MOD_BITS-1:0] mod_q, mod_d;

    logic                idle, wr_ok, xfer, last_idx, stop_eff, finish, advance;
    logic [CW-1:0]       count_ld;
    logic                ram_re;
    logic [AW-1:0]       ram_ra;
    logic [ENTRY_W-1:0]  ram_rd;

`ifdef DEBUG_IF_PLAYER_GAP_EN
    logic [7:0]          gap_cnt_q, gap_cnt_d;
`else
    logic                unused_gap;
    assign unused_gap = ^i_gap;
`endif

    // Successor of a buffer index, wrapping after the last loaded entry.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p, input logic [CW-1:0] cnt);
        return ({1'b0, p} == cnt - CW'(1)) ? '0 : p + AW'(1);
    endfunction

    assign idle      = (state_q == IDLE);
    assign o_wr_full = (count_q == CW'(DEPTH));
    assign wr_ok     = idle && i_wr_val && !i_clear && !o_wr_full;
    assign count_ld  = (idle && i_clear) ? '0 : count_q + CW'(wr_ok);
    assign xfer      = val_q && o_if.rdy;
    assign stop_eff  = stop_q || i_stop;
    assign last_idx  = ({1'b0, out_idx_q} == count_q - CW'(1));
    assign finish    = (last_idx && (!loop_q || stop_eff)) || (eop_q && stop_eff);

    debug_if_player_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk (i_clk),
        .we  (wr_ok),
        .wa  (count_q[AW-1:0]),
        .wd  (i_wr_beat),
        .re  (ram_re),
        .ra  (ram_ra),
        .rd  (ram_rd)
    );

    // Next-state, buffer bookkeeping and output-register prefetch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        out_idx_d = out_idx_q;
        loop_d    = loop_q;
        stop_d    = stop_q || (!idle && i_stop);
        done_d    = 1'b0;
        val_d     = val_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        err_d     = err_q;
        ctl_d     = ctl_q;
        dat_d     = dat_q;
        mod_d     = mod_q;
        ram_re    = 1'b0;
        ram_ra    = rd_ptr_q;
        advance   = 1'b0;
`ifdef DEBUG_IF_PLAYER_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                stop_d  = 1'b0;
                count_d = count_ld;
                if (i_start) begin
                    if (count_ld != '0) begin
                        state_d  = FETCH;
                        loop_d   = i_loop;
                        rd_ptr_d = '0;
                        ram_re   = 1'b1;
                        ram_ra   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d = PLAY;
                advance = 1'b1;
            end
            PLAY: begin
                if (xfer) begin
                    if (finish) begin
                        state_d = IDLE;
                        val_d   = 1'b0;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end
`ifdef DEBUG_IF_PLAYER_GAP_EN
                    else if (eop_q && (i_gap != 8'd0)) begin
                        state_d   = GAP;
                        val_d     = 1'b0;
                        gap_cnt_d = i_gap - 8'd1;
                    end
`endif
                    else begin
                        advance = 1'b1;
                    end
                end
            end
`ifdef DEBUG_IF_PLAYER_GAP_EN
            GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = PLAY;
                    advance = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Present the prefetched beat and fetch its successor.
        if (advance) begin
            val_d     = 1'b1;
            dat_d     = ram_rd[DAT_BITS-1:0];
            ctl_d     = ram_rd[CTL_LO +: CTL_BITS];
            mod_d     = ram_rd[MOD_LO +: MOD_BITS];
            eop_d     = ram_rd[EOP_B];
            sop_d     = ram_rd[SOP_B];
            err_d     = ram_rd[ERR_B];
            out_idx_d = rd_ptr_q;
            ram_re    = 1'b1;
            ram_ra    = next_ptr(rd_ptr_q, count_q);
            rd_ptr_d  = ram_ra;
        end
    end

    // State and output registers; reset drops val immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            out_idx_q <= '0;
            loop_q    <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            val_q     <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            ctl_q     <= '0;
            dat_q     <= '0;
            mod_q     <= '0;
`ifdef DEBUG_IF_PLAYER_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            out_idx_q <= out_idx_d;
            loop_q    <= loop_d;
            stop_q    <= stop_d;
            done_q    <= done_d;
            val_q     <= val_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
            ctl_q     <= ctl_d;
            dat_q     <= dat_d;
            mod_q     <= mod_d;
`ifdef DEBUG_IF_PLAYER_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign o_busy   = !idle;
    assign o_done   = done_q;
    assign o_if.val = val_q;
    assign o_if.sop = sop_q;
    assign o_if.eop = eop_q;
    assign o_if.err = err_q;
    assign o_if.ctl = ctl_q;
    assign o_if.dat = dat_q;
    assign o_if.mod = mod_q;
endmodule
